// File: rtl/umi_xbar_rr.sv
// umi_xbar_rr: NxM UMI crossbar, dstaddr-decoded routing, per-output round-robin with packet lock, registered outputs
// Optional feature: UMI_XBAR_MASK_EN adds input mask (bit j*N+i blocks input i -> output j).
// Ports: clk/reset (sync, active-high); umi_in_* N request ports; umi_out_* M registered ports; umi_drop per-input discard pulse.
module umi_xbar_rr #(
  parameter int N       = 4,
  parameter int M       = 4,
  parameter int CW      = 32,
  parameter int AW      = 64,
  parameter int DW      = 256,
  parameter int ID_LSB  = 40,
  parameter int IDW     = 16,
  parameter int EOM_BIT = 22
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    umi_in_valid,
  output logic [N-1:0]    umi_in_ready,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [M-1:0]    umi_out_valid,
  input  logic [M-1:0]    umi_out_ready,
  output logic [M*CW-1:0] umi_out_cmd,
  output logic [M*AW-1:0] umi_out_dstaddr,
  output logic [M*AW-1:0] umi_out_srcaddr,
  output logic [M*DW-1:0] umi_out_data,
`ifdef UMI_XBAR_MASK_EN
  input  logic [N*M-1:0]  mask,
`endif
  output logic [N-1:0]    umi_drop
);
  localparam int NW = N > 1 ? $clog2(N) : 1;
  localparam int MW = M > 1 ? $clog2(M) : 1;
  logic [M-1:0] r_lock, r_ov, w_free, w_acc;
  logic [M-1:0][NW-1:0] r_owner, r_ptr, w_k;
  logic [N-1:0] r_sink, r_drop, w_own, w_route, w_sk, w_eom;
  logic [N-1:0][MW-1:0] w_tgt;
  logic [M-1:0][N-1:0] w_req, w_gnt;
  logic [M*CW-1:0] r_cmd;
  logic [M*AW-1:0] r_dst, r_src;
  logic [M*DW-1:0] r_data;
  // Target per input: the locked output if it owns one (dest field ignored), else its decoded dest.
  always_comb begin
    w_own = '0;
    w_route = '0;
    w_tgt = '0;
    w_eom = '0;
    for (int i = 0; i < N; i++) begin
      w_eom[i] = umi_in_cmd[i*CW+EOM_BIT];
      for (int j = 0; j < M; j++)
        if (umi_in_dstaddr[i*AW+ID_LSB +: IDW] == IDW'(j)) begin
          w_tgt[i] = MW'(j);
`ifdef UMI_XBAR_MASK_EN
          w_route[i] = ~mask[j*N+i];
`else
          w_route[i] = 1'b1;
`endif
        end
      for (int j = 0; j < M; j++)
        if (r_lock[j] && r_owner[j] == NW'(i)) begin
          w_own[i] = 1'b1;
          w_tgt[i] = MW'(j);
        end
    end
    w_sk = r_sink | ~(w_own | w_route);
  end
  // Descending scan leaves w_k at the first requester at/after ptr; when locked w_k stays on the owner.
  always_comb begin
    w_req = '0;
    w_gnt = '0;
    w_k = '0;
    for (int j = 0; j < M; j++) begin
      for (int i = 0; i < N; i++)
        w_req[j][i] = umi_in_valid[i] & ~w_sk[i] & (w_tgt[i] == MW'(j));
      w_k[j] = r_owner[j];
      if (!r_lock[j])
        for (int s = N - 1; s >= 0; s--)
          if (w_req[j][NW'((int'(r_ptr[j]) + s) % N)]) w_k[j] = NW'((int'(r_ptr[j]) + s) % N);
      w_gnt[j][w_k[j]] = w_req[j][w_k[j]];
    end
  end
  assign w_free = ~r_ov | umi_out_ready;
  always_comb begin
    umi_in_ready = w_sk;
    w_acc = '0;
    for (int j = 0; j < M; j++) begin
      umi_in_ready = umi_in_ready | (w_gnt[j] & {N{w_free[j]}});
      w_acc[j] = |w_gnt[j] & w_free[j] & ~reset;
    end
    umi_in_ready = reset ? '0 : umi_in_ready;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ov <= '0;
      r_lock <= '0;
      r_owner <= '0;
      r_ptr <= '0;
      r_sink <= '0;
      r_drop <= '0;
    end else begin
      r_drop <= umi_in_valid & w_sk;
      for (int i = 0; i < N; i++)
        r_sink[i] <= (umi_in_valid[i] & w_sk[i]) ? ~w_eom[i] : r_sink[i];
      for (int j = 0; j < M; j++) begin
        r_ov[j] <= w_acc[j] | (r_ov[j] & ~umi_out_ready[j]);
        if (w_acc[j]) begin
          r_lock[j] <= ~w_eom[w_k[j]];
          r_owner[j] <= w_k[j];
          if (w_eom[w_k[j]]) r_ptr[j] <= NW'((int'(w_k[j]) + 1) % N);
        end
      end
    end
  end
  always_ff @(posedge clk)
    for (int j = 0; j < M; j++)
      if (w_acc[j]) begin
        r_cmd[j*CW +: CW] <= umi_in_cmd[int'(w_k[j])*CW +: CW];
        r_dst[j*AW +: AW] <= umi_in_dstaddr[int'(w_k[j])*AW +: AW];
        r_src[j*AW +: AW] <= umi_in_srcaddr[int'(w_k[j])*AW +: AW];
        r_data[j*DW +: DW] <= umi_in_data[int'(w_k[j])*DW +: DW];
      end
  assign umi_out_valid = r_ov;
  assign umi_out_cmd = r_cmd;
  assign umi_out_dstaddr = r_dst;
  assign umi_out_srcaddr = r_src;
  assign umi_out_data = r_data;
  assign umi_drop = r_drop;
endmodule
